// File: rtl/mux_n_lut_config.sv
// Configurable 2^N:1 mux tree with N taps, loaded through a serial
// daisy-chained configuration word that selects split, inversion and
// registering per tap.
//
// Ports:
//   CLK        in   1      rising-edge clock
//   RESET      in   1      synchronous active-high reset
//   I          in   2^N    mux data inputs
//   S          in   N      mux select
//   M          out  N      tap outputs, M[k] is the 2^(k+1):1 tap
//   MODE       in   1      1 = configuration shift, 0 = operate
//   CONFin     in   1      serial configuration in
//   CONFout    out  1      serial configuration out (chain)
//   CFG_VALID  out  1      a complete word has committed
//   CFG_ERR    out  1      sticky, a partial load was aborted
module mux_n_lut_config #(
   parameter int SEL_BITS = 3
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [(1<<SEL_BITS)-1:0]   I,
   input  logic [SEL_BITS-1:0]        S,
   output logic [SEL_BITS-1:0]        M,
   input  logic                       MODE,
   input  logic                       CONFin,
   output logic                       CONFout,
   output logic                       CFG_VALID,
   output logic                       CFG_ERR
);

   localparam int N    = SEL_BITS;
   localparam int CW   = 2 * N + 1;
   localparam int CNTW = $clog2(CW);

   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CW - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e          state_q, state_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;
   logic [CW-1:0]   sr_q,    sr_d;
   logic [CW-1:0]   act_q,   act_d;
   logic [N-1:0]    r_q,     r_d;
   logic            valid_q, valid_d;
   logic            err_q,   err_d;

   logic            split;
   logic [N-1:0]    inv;
   logic [N-1:0]    reg_en;
   logic [N-1:0]    t;
   logic [N-1:0]    v;
   logic [N-1:0]    idx;

   // Active configuration fields; the shift register never
   // influences the datapath directly.
   assign split  = act_q[CW-1];
   assign inv    = act_q[2*N-1:N];
   assign reg_en = act_q[N-1:0];

   // Tap k selects among the lowest 2^(k+1) inputs using S[k:0].
   // With split set, the widest tap instead reads the upper half.
   always_comb begin
      t   = '0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         idx = '0;
         for (int j = 0; j <= k; j++) begin
            idx[j] = S[j];
         end
         if (k == N - 1 && split) begin
            idx[N-1] = 1'b1;
         end
         t[k] = I[idx];
      end
   end

   assign v = t ^ inv;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         M[k] = reg_en[k] ? r_q[k] : v[k];
      end
   end

   assign CONFout   = sr_q[CW-1];
   assign CFG_VALID = valid_q;
   assign CFG_ERR   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      act_d   = act_q;
      r_d     = r_q;
      valid_d = valid_q;
      err_d   = err_q;

      // Registered taps freeze while configuration is shifting.
      if (MODE) begin
         sr_d = {sr_q[CW-2:0], CONFin};
      end else begin
         r_d = v;
      end

      unique case (state_q)
         IDLE: begin
            if (MODE) begin
               state_d = SHIFT;
               cnt_d   = CNT_ONE;
            end
         end
         SHIFT: begin
            if (MODE) begin
               if (cnt_q == CNT_LAST) begin
                  // Commit includes the bit arriving on this edge.
                  act_d   = {sr_q[CW-2:0], CONFin};
                  cnt_d   = '0;
                  valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
               if (cnt_q != '0) begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         act_q   <= '0;
         r_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         act_q   <= act_d;
         r_q     <= r_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mux_n_lut_config.sv
// Randomized and directed bench for mux_n_lut_config (N=3) with a
// behavioural reference model and per-cycle output comparison.
module tb_mux_n_lut_config;

   localparam int N  = 3;
   localparam int CW = 2 * N + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   i_d;
   logic [N-1:0] s_d;
   logic [N-1:0] m_o;
   logic         mode;
   logic         cin;
   logic         cout;
   logic         valid_o;
   logic         err_o;

   int nvec = 0;
   int nerr = 0;

   mux_n_lut_config #(.SEL_BITS(N)) dut (
      .CLK       (clk),
      .RESET     (rst),
      .I         (i_d),
      .S         (s_d),
      .M         (m_o),
      .MODE      (mode),
      .CONFin    (cin),
      .CONFout   (cout),
      .CFG_VALID (valid_o),
      .CFG_ERR   (err_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit           known = 0;
   bit           mq[$];
   int           m_cnt;
   bit           m_split;
   bit [N-1:0]   m_inv;
   bit [N-1:0]   m_reg;
   bit [N-1:0]   m_r;
   bit           m_valid;
   bit           m_err;

   function automatic bit [N-1:0] exp_v(logic [7:0] iv, logic [N-1:0] sv);
      bit [N-1:0] res;
      int sel;
      for (int k = 0; k < N; k++) begin
         sel = int'(sv) % (1 << (k + 1));
         if (k == N - 1 && m_split)
            sel = (1 << (N - 1)) + int'(sv) % (1 << (N - 1));
         res[k] = iv[sel] ^ m_inv[k];
      end
      return res;
   endfunction

   function automatic bit [N-1:0] exp_m(logic [7:0] iv, logic [N-1:0] sv);
      bit [N-1:0] vv;
      bit [N-1:0] res;
      vv = exp_v(iv, sv);
      for (int k = 0; k < N; k++)
         res[k] = m_reg[k] ? m_r[k] : vv[k];
      return res;
   endfunction

   task automatic model_edge();
      bit [N-1:0] vv;
      if (rst === 1'b1) begin
         mq.delete();
         for (int j = 0; j < CW; j++) mq.push_back(1'b0);
         m_cnt = 0; m_split = 0; m_inv = '0; m_reg = '0;
         m_r = '0; m_valid = 0; m_err = 0; known = 1;
      end else if (known) begin
         vv = exp_v(i_d, s_d);
         if (mode) begin
            mq.push_back(cin);
            void'(mq.pop_front());
            m_cnt++;
            if (m_cnt == CW) begin
               // mq[0] is the first bit of the word just completed
               m_split = mq[0];
               for (int k = 0; k < N; k++) begin
                  m_inv[k] = mq[CW - 1 - N - k];
                  m_reg[k] = mq[CW - 1 - k];
               end
               m_cnt   = 0;
               m_valid = 1;
            end
         end else begin
            if (m_cnt != 0) m_err = 1;
            m_cnt = 0;
            m_r   = vv;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                  $time);
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (known) begin
            chk("M", 32'(m_o), 32'(exp_m(i_d, s_d)));
            chk("CONFout", 32'(cout), 32'(mq[0]));
            chk("CFG_VALID", 32'(valid_o), 32'(m_valid));
            chk("CFG_ERR", 32'(err_o), 32'(m_err));
         end
         @(posedge clk);
         model_edge();
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(logic r, logic md, logic c, logic [7:0] iv,
                      logic [N-1:0] sv);
      @(negedge clk);
      rst = r; mode = md; cin = c; i_d = iv; s_d = sv;
   endtask

   task automatic rcyc(logic md, logic c);
      cyc(1'b0, md, c, 8'($urandom), N'($urandom));
   endtask

   task automatic load(logic [CW-1:0] w);
      for (int j = CW - 1; j >= 0; j--) rcyc(1'b1, w[j]);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 8'h00, '0);
      cyc(1'b1, 1'b1, 1'b1, 8'hFF, '1);
   endtask

   initial begin
      int run;
      rst = 1'b1; mode = 1'b0; cin = 1'b0; i_d = '0; s_d = '0;

      // reset state, plain mux behaviour
      do_reset();
      cyc(1'b0, 1'b0, 1'b0, 8'hAA, 3'b011);
      #4;
      chk("rst_M", 32'(m_o), 32'h7);
      chk("rst_CONFout", 32'(cout), 32'h0);
      chk("rst_VALID", 32'(valid_o), 32'h0);
      chk("rst_ERR", 32'(err_o), 32'h0);

      // split load
      load(7'b1000000);
      cyc(1'b0, 1'b0, 1'b0, 8'h80, 3'b011);
      #4;
      chk("split_VALID", 32'(valid_o), 32'h1);
      chk("split_M2", 32'(m_o[2]), 32'h1);
      chk("split_M1", 32'(m_o[1]), 32'h0);
      chk("split_CONFout", 32'(cout), 32'h1);

      // aborted load, then full load
      do_reset();
      for (int j = 0; j < 4; j++) rcyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b000);
      cyc(1'b0, 1'b0, 1'b0, 8'hAA, 3'b011);
      #4;
      chk("abort_ERR", 32'(err_o), 32'h1);
      chk("abort_VALID", 32'(valid_o), 32'h0);
      chk("abort_M", 32'(m_o), 32'h7);
      load(7'b0000000);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b000);
      #4;
      chk("reload_VALID", 32'(valid_o), 32'h1);
      chk("reload_ERR", 32'(err_o), 32'h1);

      // inversion + registered tap
      do_reset();
      load(7'b0001100);
      cyc(1'b0, 1'b0, 1'b0, 8'h0F, 3'b010);
      #4;
      chk("inv_M0", 32'(m_o[0]), 32'h0);
      chk("reg_M2_pre", 32'(m_o[2]), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 8'h0F, 3'b010);
      #4;
      chk("reg_M2", 32'(m_o[2]), 32'h1);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 3'b010);
      #4;
      chk("hold_M2", 32'(m_o[2]), 32'h1);
      chk("hold_M0", 32'(m_o[0]), 32'h1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b010);

      // 14 continuous bits -> two commits
      do_reset();
      rcyc(1'b1, 1'b1);
      for (int j = 1; j < 7; j++) rcyc(1'b1, 1'($urandom));
      rcyc(1'b1, 1'($urandom));
      #4;
      chk("chain_CONFout", 32'(cout), 32'h1);
      chk("chain_VALID", 32'(valid_o), 32'h1);
      for (int j = 9; j <= 14; j++) rcyc(1'b1, 1'($urandom));
      rcyc(1'b0, 1'b0);
      #4;
      chk("chain_ERR", 32'(err_o), 32'h0);

      // reset in the middle of a load
      do_reset();
      rcyc(1'b1, 1'b1);
      rcyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 8'h00, '0);
      rcyc(1'b0, 1'b0);
      #4;
      chk("midrst_ERR", 32'(err_o), 32'h0);
      chk("midrst_VALID", 32'(valid_o), 32'h0);
      chk("midrst_CONFout", 32'(cout), 32'h0);
      load(7'($urandom));
      rcyc(1'b0, 1'b0);
      #4;
      chk("midrst_reload", 32'(valid_o), 32'h1);

      // random traffic
      for (int blk = 0; blk < 120; blk++) begin
         run = $urandom_range(1, 16);
         for (int j = 0; j < run; j++) begin
            if ($urandom_range(0, 99) == 0)
               cyc(1'b1, 1'($urandom), 1'($urandom), 8'($urandom),
                   N'($urandom));
            else
               rcyc(1'b1, 1'($urandom));
         end
         run = $urandom_range(1, 5);
         for (int j = 0; j < run; j++) rcyc(1'b0, 1'($urandom));
      end

      rcyc(1'b0, 1'b0);
      rcyc(1'b0, 1'b0);
      @(negedge clk);
      #5;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mux_n_lut_config.md
MUX_N_LUT_CONFIG -- requirements
Module: mux_n_lut_config

Interface
REQ-001 SHALL provide parameter SEL_BITS, default 3, meaning select width N; data inputs = 2^N, taps = N; legal range 2..5.
REQ-002 SHALL derive local constant CW = 2*N+1, meaning configuration word width (7 at default).
REQ-003 SHALL provide CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide RESET  input  1  synchronous active-high reset.
REQ-005 SHALL provide I  input  2^N  mux data inputs.
REQ-006 SHALL provide S  input  N  mux select.
REQ-007 SHALL provide M  output  N  tap outputs; M[k] is the 2^(k+1):1 tap.
REQ-008 SHALL provide MODE  input  1  1 = configuration shift, 0 = operate.
REQ-009 SHALL provide CONFin  input  1  serial configuration in.
REQ-010 SHALL provide CONFout  output  1  serial configuration out (daisy chain).
REQ-011 SHALL provide CFG_VALID  output  1  high once at least one complete word has committed.
REQ-012 SHALL provide CFG_ERR  output  1  sticky; a load was aborted.

Function
REQ-013 SHALL hold a CW-bit shift register SR; on each edge with MODE=1: SR <= {SR[CW-2:0], CONFin}.
REQ-014 SHALL drive CONFout = SR[CW-1] (registered, CW-cycle chain delay).
REQ-015 SHALL hold a separate active config ACT; mux behaviour uses ACT only, never SR.
REQ-016 SHALL map ACT as: [CW-1] SPLIT, [2N-1:N] INV[N-1:0], [N-1:0] REG_EN[N-1:0]; first bit shifted in lands in SPLIT.
REQ-017 SHALL implement FSM states IDLE and SHIFT with bit counter CNT (width ceil(log2(CW))).
REQ-018 IDLE: MODE=1 -> SHIFT, CNT <= 1 (this edge shifts bit 0); MODE=0 -> stay.
REQ-019 SHIFT, MODE=1, CNT<CW-1: CNT <= CNT+1.
REQ-020 SHIFT, MODE=1, CNT=CW-1: commit ACT <= {SR[CW-2:0], CONFin} on the same edge, CNT <= 0, CFG_VALID <= 1, stay in SHIFT.
REQ-021 SHIFT, MODE=0, CNT=0: -> IDLE cleanly; no flag change.
REQ-022 SHIFT, MODE=0, CNT!=0 (partial word): -> IDLE, CNT <= 0, CFG_ERR <= 1, ACT unchanged, SR retains partial contents.
REQ-023 Base tap: T[k] = I[S[k:0]] over I[2^(k+1)-1:0], combinational.
REQ-024 SPLIT=1: T[N-1] SHALL instead be I[2^(N-1)+S[N-2:0]] (upper half); taps 0..N-2 unaffected.
REQ-025 Inverted tap: V[k] = T[k] XOR INV[k].
REQ-026 REG_EN[k]=0: M[k] = V[k] combinationally, including while MODE=1.
REQ-027 REG_EN[k]=1: M[k] = flop R[k]; R[k] <= V[k] each edge with MODE=0; R[k] holds while MODE=1; latency 1 cycle.
REQ-028 An ACT commit SHALL take effect on combinational taps immediately after the commit edge; R flops are not cleared by a commit.
REQ-029 CFG_ERR SHALL clear only by RESET; a subsequent successful commit leaves it set.

Reset
REQ-030 RESET=1 at an edge SHALL force SR=0, ACT=0, CNT=0, state IDLE, R=0, CFG_VALID=0, CFG_ERR=0; RESET overrides MODE.
REQ-031 After reset, M = T (no split, no inversion, all combinational); CONFout = 0.
REQ-032 RESET during SHIFT SHALL discard the partial word without setting CFG_ERR.

Verification (N=3, CW=7)
REQ-033 Reset, then shift 1,0,0,0,0,0,0 (MODE=1, 7 edges), MODE=0; I=8'h80, S=3'b011 -> CFG_VALID=1, M[2]=1 (split, I[7]); M[1]=I[3]=0.
REQ-034 From reset, shift 4 bits, drop MODE -> CFG_ERR=1, CFG_VALID=0, M unchanged from reset behaviour; a full 7-bit load afterwards -> CFG_VALID=1, CFG_ERR stays 1.
REQ-035 Load SPLIT=0, INV=3'b001, REG=3'b100; I=8'h0F, S=3'b010 -> M[0]=0 (I[0]=1 inverted), M[2] follows I[2]=1 one cycle later; with MODE=1, change I=8'h00 -> M[2] holds 1.
REQ-036 Shift 14 bits continuously with MODE=1 -> two commits (edges 7 and 14), CFG_ERR=0; CONFout at edge 7 equals first bit shifted.
REQ-037 Assert RESET on edge 3 of a load -> all state zero, CFG_ERR=0; new full load commits normally.
